// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural widths, reset vector and the fetch packet
// handed from fetch to decode.
package riscv_pkg;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned ILEN         = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_0000_0000;
    localparam logic [ILEN-1:0] INSTR_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is exposed combinationally from
// registered storage so decode sees the oldest packet without an extra cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s, wr_en_s, full_s;

    // A push into a full FIFO is legal when the head is popped in the same cycle.
    always_comb begin
        full_s    = (count_q == CW'(DEPTH));
        empty_o   = (count_q == CW'(0));
        do_push_s = push_i && (!full_s || pop_i);
        do_pop_s  = pop_i && !empty_o;
        wr_en_s   = do_push_s && !flush_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: issues addresses to the registered-read instruction memory, buffers the
// returned words with their PCs and hands {pc,instr} to decode; redirects flush and squash.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = XLEN,
    parameter int unsigned       INSTR_W   = ILEN,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_VECTOR),
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               misalign_err
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned PKT_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              misalign_q, misalign_d;

    logic [CW-1:0]     fifo_count_s;
    logic              fifo_empty_s;
    logic [PKT_W-1:0]  head_s;
    logic              pop_s, push_s, issue_s, valid_s;
    logic [OW-1:0]     occupancy_s;

    // Issue only if the word coming back next cycle is guaranteed a free buffer slot.
    always_comb begin
        valid_s     = !fifo_empty_s && !redirect_valid;
        pop_s       = valid_s && out_ready;
        push_s      = inflight_q && !redirect_valid;
        occupancy_s = OW'(fifo_count_s) + OW'(inflight_q) - OW'(pop_s);
        issue_s     = (occupancy_s < OW'(BUF_DEPTH)) && !redirect_valid;
        misalign_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end else if (issue_s) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(3'd4);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .data_i  ({inflight_pc_q, imem_instr}),
        .data_o  (head_s),
        .count_o (fifo_count_s),
        .empty_o (fifo_empty_s)
    );

    assign imem_pc      = fetch_pc_q;
    assign out_valid    = valid_s;
    assign out_pc       = head_s[PKT_W-1:INSTR_W];
    assign out_instr    = head_s[INSTR_W-1:0];
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural registered-read program image.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] image(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h0000_0013;
    endfunction

    always @(posedge clk) imem_instr <= image(imem_pc);

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = ready;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_pc !== 64'h0) $display("FAIL reset_pc: got %h exp 0", out_pc); else pass_cnt++;
        total_cnt++; if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h exp 0", out_instr); else pass_cnt++;
        total_cnt++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b exp 0", misalign_err); else pass_cnt++;
        total_cnt++; if (imem_pc !== 64'h0) $display("FAIL reset_imem_pc: got %h exp 0", imem_pc); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL first_edge_valid: got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (imem_pc !== 64'h4) $display("FAIL first_edge_imem_pc: got %h exp 4", imem_pc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL second_edge_valid: got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_pc !== 64'h0) $display("FAIL second_edge_pc: got %h exp 0", out_pc); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b exp 1", k, out_valid); else pass_cnt++;
            total_cnt++; if (out_pc !== 64'(4 * k)) $display("FAIL stream_pc[%0d]: got %h exp %h", k, out_pc, 64'(4 * k)); else pass_cnt++;
            total_cnt++; if (out_instr !== image(64'(4 * k))) $display("FAIL stream_instr[%0d]: got %h exp %h", k, out_instr, image(64'(4 * k))); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h0) $display("FAIL bp_hold[%0d]: got valid %b pc %h exp 1 0", i, out_valid, out_pc); else pass_cnt++;
            total_cnt++; if (imem_pc !== 64'h8) $display("FAIL bp_imem_pc[%0d]: got %h exp 8", i, imem_pc); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (dut.u_fifo.count_q !== 2'd2) $display("FAIL bp_count: got %0d exp 2", dut.u_fifo.count_q); else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) $display("FAIL bp_release[%0d]: got valid %b pc %h exp 1 %h", k, out_valid, out_pc, 64'(4 * k)); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        total_cnt++; if (out_pc !== 64'h8) $display("FAIL redir_pre_pc: got %h exp 8", out_pc); else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_mask: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk); redirect_valid = 1'b0;
        total_cnt++; if (imem_pc !== 64'h40) $display("FAIL redir_imem_pc: got %h exp 40", imem_pc); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_n1_valid: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_n2_valid: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h40) $display("FAIL redir_target: got valid %b pc %h exp 1 40", out_valid, out_pc); else pass_cnt++;
        total_cnt++; if (out_instr !== image(64'h40)) $display("FAIL redir_instr: got %h exp %h", out_instr, image(64'h40)); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h44) $display("FAIL redir_next: got valid %b pc %h exp 1 44", out_valid, out_pc); else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        #1;
        total_cnt++; if (misalign_err !== 1'b0) $display("FAIL mis_n0: got %b exp 0", misalign_err); else pass_cnt++;
        @(negedge clk); redirect_valid = 1'b0; redirect_pc = 64'h0;
        total_cnt++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse: got %b exp 1", misalign_err); else pass_cnt++;
        total_cnt++; if (imem_pc !== 64'h40) $display("FAIL mis_imem_pc: got %h exp 40", imem_pc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (misalign_err !== 1'b0) $display("FAIL mis_clear: got %b exp 0", misalign_err); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h40) $display("FAIL mis_target: got valid %b pc %h exp 1 40", out_valid, out_pc); else pass_cnt++;
    endtask

    task automatic test_redirect_handshake();
        int accepted;
        accepted = 0;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        #1;
        if (out_valid && out_ready) accepted++;
        total_cnt++; if (accepted !== 0) $display("FAIL hs_accepted: got %0d exp 0", accepted); else pass_cnt++;
        @(negedge clk); redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL hs_n2_valid: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h80) $display("FAIL hs_target: got valid %b pc %h exp 1 80", out_valid, out_pc); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        @(negedge clk); redirect_pc = 64'h100;
        @(negedge clk); redirect_valid = 1'b0;
        total_cnt++; if (imem_pc !== 64'h100) $display("FAIL b2b_imem_pc: got %h exp 100", imem_pc); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_n1_valid: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_n2_valid: got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h100) $display("FAIL b2b_target: got valid %b pc %h exp 1 100", out_valid, out_pc); else pass_cnt++;
    endtask

    task automatic test_wrap_and_reset();
        logic [63:0] exp_pc;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk); redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_pc !== exp_pc) $display("FAIL wrap_pc[%0d]: got valid %b pc %h exp 1 %h", k, out_valid, out_pc, exp_pc); else pass_cnt++;
            total_cnt++; if (out_instr !== image(exp_pc)) $display("FAIL wrap_instr[%0d]: got %h exp %h", k, out_instr, image(exp_pc)); else pass_cnt++;
            exp_pc = exp_pc + 64'd4;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (imem_pc !== 64'h0) $display("FAIL midrst_imem_pc: got %h exp 0", imem_pc); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_pc !== 64'h0) $display("FAIL midrst_restart: got valid %b pc %h exp 1 0", out_valid, out_pc); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_redirect_handshake();
        test_back_to_back();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
